mem_port_arbiter: RTL

- Two-requester arbiter that shares the single 128-bit line-granular memory port between the instruction cache (port 0) and the data cache (port 1).
- Each requester uses the same valid/ready line-transfer protocol the caches already drive (17-bit byte address, 128-bit line, write flag).
- The arbiter latches one request at a time, issues it downstream, and routes the response back.
- Round-robin fairness; optional watchdog aborts hung transfers.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one line-granular memory port between the instruction cache
// (port 0) and the data cache (port 1). One request is latched at a time,
// issued downstream, and its completion is routed back to the owner.
// Contention is resolved round-robin. An optional watchdog aborts a
// transfer that the memory never completes.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid / i_req_wr [1:0] per-port request valid / write flag
//   i_req_addr0/1, i_req_wdata0/1  per-port address and write line
//   o_req_ready / o_req_err [1:0]  one-cycle completion / abort pulse
//   o_rsp_rdata                  read line, valid while o_req_ready is set
//   o_mem_req_*, o_mem_wr_data   downstream request fields
//   i_mem_rd_data, i_mem_req_ready downstream read line / completion pulse
//   o_busy                       high whenever a transfer is in flight
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; pick a winner from i_req_valid and latch it
// ISSUE | downstream request held; wait for ready or watchdog expiry
// RESP  | single cycle; pulse ready/err to the owner, advance rr pointer

module mem_port_arbiter #(
    parameter int ADDR_BITS      = 17,
    parameter int LINE_BITS      = 128,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req_valid,
    input  logic [1:0]           i_req_wr,
    input  logic [ADDR_BITS-1:0] i_req_addr0,
    input  logic [ADDR_BITS-1:0] i_req_addr1,
    input  logic [LINE_BITS-1:0] i_req_wdata0,
    input  logic [LINE_BITS-1:0] i_req_wdata1,
    output logic [1:0]           o_req_ready,
    output logic [1:0]           o_req_err,
    output logic [LINE_BITS-1:0] o_rsp_rdata,
    output logic                 o_mem_req_valid,
    output logic                 o_mem_req_wr,
    output logic [ADDR_BITS-1:0] o_mem_req_addr,
    output logic [LINE_BITS-1:0] o_mem_wr_data,
    input  logic [LINE_BITS-1:0] i_mem_rd_data,
    input  logic                 i_mem_req_ready,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam bit                 WDOG_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_W-1:0] WDOG_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);

    state_t                 r_state;
    logic                   r_rr_ptr;
    logic                   r_owner;
    logic                   r_err_flag;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic [1:0]             r_req_ready;
    logic [1:0]             r_req_err;
    logic [LINE_BITS-1:0]   r_rsp_rdata;
    logic                   r_mem_req_valid;
    logic                   r_mem_req_wr;
    logic [ADDR_BITS-1:0]   r_mem_req_addr;
    logic [LINE_BITS-1:0]   r_mem_wr_data;
    logic                   r_busy;

    logic                   w_any_req;
    logic                   w_winner;
    logic                   w_wdog_hit;

    // With both ports requesting the pointer decides; otherwise the single
    // requester wins, which is port 1 exactly when bit 1 is the set bit.
    always_comb begin
        w_any_req  = |i_req_valid;
        w_winner   = (&i_req_valid) ? r_rr_ptr : i_req_valid[1];
        // r_wdog holds the index of the current ISSUE cycle (first = 1).
        w_wdog_hit = WDOG_EN && (r_wdog == WDOG_LIM);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= 1'b0;
            r_owner         <= 1'b0;
            r_err_flag      <= 1'b0;
            r_wdog          <= '0;
            r_req_ready     <= 2'b00;
            r_req_err       <= 2'b00;
            r_rsp_rdata     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_wr    <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_wr_data   <= '0;
            r_busy          <= 1'b0;
        end else begin
            // Completion/abort flags are single-cycle pulses.
            r_req_ready <= 2'b00;
            r_req_err   <= 2'b00;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner         <= w_winner;
                        r_mem_req_addr  <= w_winner ? i_req_addr1  : i_req_addr0;
                        r_mem_wr_data   <= w_winner ? i_req_wdata1 : i_req_wdata0;
                        r_mem_req_wr    <= i_req_wr[w_winner];
                        r_mem_req_valid <= 1'b1;
                        r_wdog          <= WDOG_EN ? TIMEOUT_W'(1) : '0;
                        r_busy          <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // Ready takes priority over a watchdog expiry in the same cycle.
                    if (i_mem_req_ready || w_wdog_hit) begin
                        if (i_mem_req_ready) begin
                            r_rsp_rdata <= i_mem_rd_data;
                        end
                        r_err_flag      <= !i_mem_req_ready;
                        r_req_ready     <= r_owner ? 2'b10 : 2'b01;
                        r_req_err       <= i_mem_req_ready ? 2'b00
                                                           : (r_owner ? 2'b10 : 2'b01);
                        r_mem_req_valid <= 1'b0;
                        r_wdog          <= '0;
                        r_state         <= ST_RESP;
                    end else if (WDOG_EN) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end

                ST_RESP: begin
                    r_rr_ptr <= ~r_owner;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_busy          <= 1'b0;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_req_err       = r_req_err;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_req_wr    = r_mem_req_wr;
    assign o_mem_req_addr  = r_mem_req_addr;
    assign o_mem_wr_data   = r_mem_wr_data;
    assign o_busy          = r_busy;

endmodule
